frame_buffer_scanout: RTL and testbench

//  Read-side master of the double-buffered frame_buffer. Generates 640x480@60 VGA timing.

---
 rtl/video_params.sv | 20 ++
 rtl/frame_buffer_scanout_vga_timing.sv | 63 ++++++
 rtl/frame_buffer_scanout.sv | 109 ++++++++++
 tb/tb_frame_buffer_scanout.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_params.sv
// 640x480@60 VGA timing constants shared by the drawers, the frame buffer and the scanout.
package video_params;

    localparam int HOR_ACTIVE_PIXELS = 640;
    localparam int HOR_FRONT_PORCH   = 16;
    localparam int HOR_SYNC_PIXELS   = 96;
    localparam int HOR_TOTAL_PIXELS  = 800;
    localparam int VER_ACTIVE_PIXELS = 480;
    localparam int VER_FRONT_PORCH   = 10;
    localparam int VER_SYNC_PIXELS   = 2;
    localparam int VER_TOTAL_PIXELS  = 525;
    localparam int SYNC_ACTIVE_LOW   = 1;
    localparam int ADDR_WIDTH        = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);

    // Maps a logical "sync asserted" flag onto the pin level for the chosen polarity.
    function automatic logic drive_sync(input logic asserted, input int active_low);
        return (active_low != 0) ? ~asserted : asserted;
    endfunction

endpackage

// File: rtl/frame_buffer_scanout_vga_timing.sv
// Horizontal/vertical scan counters with combinational active, sync windows and
// the frame_end marker at the last cycle of the last active line.
module vga_timing
    import video_params::*;
#(
    parameter int H_ACTIVE = HOR_ACTIVE_PIXELS,
    parameter int H_FP     = HOR_FRONT_PORCH,
    parameter int H_SYNC   = HOR_SYNC_PIXELS,
    parameter int H_TOTAL  = HOR_TOTAL_PIXELS,
    parameter int V_ACTIVE = VER_ACTIVE_PIXELS,
    parameter int V_FP     = VER_FRONT_PORCH,
    parameter int V_SYNC   = VER_SYNC_PIXELS,
    parameter int V_TOTAL  = VER_TOTAL_PIXELS
) (
    input  logic clk,
    input  logic rst_n,
    output logic active,
    output logic hs,
    output logic vs,
    output logic frame_end
);

    localparam int H_W = $clog2(H_TOTAL);
    localparam int V_W = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] HS_FIRST = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_ACT_LAST = V_W'(V_ACTIVE - 1);
    localparam logic [V_W-1:0] VS_FIRST = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q + H_W'(1);
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign active    = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs        = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    assign vs        = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    assign frame_end = (h_q == H_LAST) && (v_q == V_ACT_LAST);

endmodule

// File: rtl/frame_buffer_scanout.sv
// Read-side master of the double-buffered frame buffer: VGA timing, linear read
// address, two-stage output pipeline and the per-frame buffer swap pulse.
module frame_buffer_scanout
    import video_params::drive_sync;
#(
    parameter int HOR_ACTIVE_PIXELS = video_params::HOR_ACTIVE_PIXELS,
    parameter int HOR_FRONT_PORCH   = video_params::HOR_FRONT_PORCH,
    parameter int HOR_SYNC_PIXELS   = video_params::HOR_SYNC_PIXELS,
    parameter int HOR_TOTAL_PIXELS  = video_params::HOR_TOTAL_PIXELS,
    parameter int VER_ACTIVE_PIXELS = video_params::VER_ACTIVE_PIXELS,
    parameter int VER_FRONT_PORCH   = video_params::VER_FRONT_PORCH,
    parameter int VER_SYNC_PIXELS   = video_params::VER_SYNC_PIXELS,
    parameter int VER_TOTAL_PIXELS  = video_params::VER_TOTAL_PIXELS,
    parameter int SYNC_ACTIVE_LOW   = video_params::SYNC_ACTIVE_LOW,
    localparam int ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_data,
    output logic                  swap,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  pixel_de,
    output logic                  pixel
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST =
        ADDR_WIDTH'(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS - 1);
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic active, hs, vs, frame_end;

    vga_timing #(
        .H_ACTIVE (HOR_ACTIVE_PIXELS),
        .H_FP     (HOR_FRONT_PORCH),
        .H_SYNC   (HOR_SYNC_PIXELS),
        .H_TOTAL  (HOR_TOTAL_PIXELS),
        .V_ACTIVE (VER_ACTIVE_PIXELS),
        .V_FP     (VER_FRONT_PORCH),
        .V_SYNC   (VER_SYNC_PIXELS),
        .V_TOTAL  (VER_TOTAL_PIXELS)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (active),
        .hs        (hs),
        .vs        (vs),
        .frame_end (frame_end)
    );

    logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
    logic active_d1_q, active_d1_d;
    logic hs_d1_q, hs_d1_d;
    logic vs_d1_q, vs_d1_d;
    logic pixel_de_q, pixel_de_d;
    logic pixel_q, pixel_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic swap_q, swap_d;

    always_comb begin
        // Address tracks the active raster only, so it parks on the next line's start in blanking.
        read_addr_d = read_addr_q;
        if (active) begin
            read_addr_d = (read_addr_q == ADDR_LAST) ? '0 : read_addr_q + ADDR_WIDTH'(1);
        end
        active_d1_d = active;
        hs_d1_d     = hs;
        vs_d1_d     = vs;
        pixel_de_d  = active_d1_q;
        pixel_d     = read_data & active_d1_q;
        hsync_d     = drive_sync(hs_d1_q, SYNC_ACTIVE_LOW);
        vsync_d     = drive_sync(vs_d1_q, SYNC_ACTIVE_LOW);
        swap_d      = frame_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_addr_q <= '0;
            active_d1_q <= 1'b0;
            hs_d1_q     <= 1'b0;
            vs_d1_q     <= 1'b0;
            pixel_de_q  <= 1'b0;
            pixel_q     <= 1'b0;
            hsync_q     <= SYNC_IDLE;
            vsync_q     <= SYNC_IDLE;
            swap_q      <= 1'b0;
        end else begin
            read_addr_q <= read_addr_d;
            active_d1_q <= active_d1_d;
            hs_d1_q     <= hs_d1_d;
            vs_d1_q     <= vs_d1_d;
            pixel_de_q  <= pixel_de_d;
            pixel_q     <= pixel_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            swap_q      <= swap_d;
        end
    end

    assign read_addr = read_addr_q;
    assign swap      = swap_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign pixel_de  = pixel_de_q;
    assign pixel     = pixel_q;

endmodule

// File: tb/tb_frame_buffer_scanout.sv
// Directed bench: full 640x480 instance for line-level timing, a shrunken-geometry
// instance for frame-level timing, swap pulses, pixel pattern and mid-frame reset.
module tb_frame_buffer_scanout;

    localparam int S_HA = 8;
    localparam int S_HFP = 2;
    localparam int S_HS = 3;
    localparam int S_HT = 16;
    localparam int S_VA = 6;
    localparam int S_VFP = 2;
    localparam int S_VS = 2;
    localparam int S_VT = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [18:0] read_addr_a;
    logic read_data_a = 1'b0;
    logic swap_a, hsync_a, vsync_a, de_a, pix_a;
    logic [5:0] read_addr_s;
    logic read_data_s = 1'b0;
    logic swap_s, hsync_s, vsync_s, de_s, pix_s;
    logic blank_a = 1'b1;
    logic blank_s = 1'b1;

    frame_buffer_scanout dut_a (
        .clk(clk), .rst_n(rst_n), .read_addr(read_addr_a), .read_data(read_data_a),
        .swap(swap_a), .hsync(hsync_a), .vsync(vsync_a), .pixel_de(de_a), .pixel(pix_a)
    );

    frame_buffer_scanout #(
        .HOR_ACTIVE_PIXELS(S_HA), .HOR_FRONT_PORCH(S_HFP), .HOR_SYNC_PIXELS(S_HS),
        .HOR_TOTAL_PIXELS(S_HT), .VER_ACTIVE_PIXELS(S_VA), .VER_FRONT_PORCH(S_VFP),
        .VER_SYNC_PIXELS(S_VS), .VER_TOTAL_PIXELS(S_VT), .SYNC_ACTIVE_LOW(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .read_addr(read_addr_s), .read_data(read_data_s),
        .swap(swap_s), .hsync(hsync_s), .vsync(vsync_s), .pixel_de(de_s), .pixel(pix_s)
    );

    function automatic logic pat_a(input logic [18:0] a);
        return a[0] ^ a[10];
    endfunction

    function automatic logic pat_s(input logic [5:0] a);
        return a[0] ^ a[2];
    endfunction

    // 1-cycle-latency frame buffer models; blanking reads return 1 to prove the output mask.
    always @(posedge clk) read_data_a <= blank_a ? 1'b1 : pat_a(read_addr_a);
    always @(posedge clk) read_data_s <= blank_s ? 1'b1 : pat_s(read_addr_s);

    int n_cmp = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];
    int de_rises[$], de_falls[$], hs_rises[$], hs_falls[$];
    int vs_rises[$], vs_falls[$], sw[$];
    int x, y, ra, de_cnt, vs_low_a, swap_cnt_a;
    logic act, prev_de, prev_hs, prev_vs;
    logic [0:0] exp_pix;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_ra_a"}, 32'(read_addr_a), 0);
        check({tag, "_swap_a"}, 32'(swap_a), 0);
        check({tag, "_de_a"}, 32'(de_a), 0);
        check({tag, "_pix_a"}, 32'(pix_a), 0);
        check({tag, "_hs_a"}, 32'(hsync_a), 1);
        check({tag, "_vs_a"}, 32'(vsync_a), 1);
    endtask

    task automatic check_idle_s(input string tag);
        check({tag, "_ra_s"}, 32'(read_addr_s), 0);
        check({tag, "_swap_s"}, 32'(swap_s), 0);
        check({tag, "_de_s"}, 32'(de_s), 0);
        check({tag, "_pix_s"}, 32'(pix_s), 0);
        check({tag, "_hs_s"}, 32'(hsync_s), 1);
        check({tag, "_vs_s"}, 32'(vsync_s), 1);
    endtask

    // Holds reset for the given cycles and returns on the releasing negedge (cycle 0).
    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state of both instances
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_idle_a("rst");
        check_idle_s("rst");

        // Full-size instance: two lines plus a little
        rst_n = 1'b1;
        exp_q = {1'b0, 1'b0};
        prev_de = 1'b0;
        prev_hs = 1'b1;
        vs_low_a = 0;
        swap_cnt_a = 0;
        for (int k = 0; k < 1700; k++) begin
            if (k > 0) @(negedge clk);
            x = k % 800;
            y = k / 800;
            act = (x < 640);
            ra = y * 640 + ((x < 640) ? x : 640);
            check("ra_a", 32'(read_addr_a), 32'(ra));
            exp_pix = exp_q.pop_front();
            check("pix_a", 32'(pix_a), 32'(exp_pix));
            exp_q.push_back(act ? pat_a(19'(ra)) : 1'b0);
            blank_a = !act;
            if (de_a && !prev_de) de_rises.push_back(k);
            if (!de_a && prev_de) de_falls.push_back(k);
            if (hsync_a && !prev_hs) hs_rises.push_back(k);
            if (!hsync_a && prev_hs) hs_falls.push_back(k);
            if (!vsync_a) vs_low_a++;
            if (swap_a) swap_cnt_a++;
            prev_de = de_a;
            prev_hs = hsync_a;
        end
        check("de_rises_n", 32'(de_rises.size()), 3);
        check("de_falls_n", 32'(de_falls.size()), 2);
        check("de_rise0", 32'(de_rises[0]), 2);
        check("de_fall0", 32'(de_falls[0]), 642);
        check("de_rise1", 32'(de_rises[1]), 802);
        check("hs_falls_n", 32'(hs_falls.size()), 2);
        check("hs_fall0", 32'(hs_falls[0]), 658);
        check("hs_rise0", 32'(hs_rises[0]), 754);
        check("hs_fall1", 32'(hs_falls[1]), 1458);
        check("vs_low_a", 32'(vs_low_a), 0);
        check("swap_a_lines", 32'(swap_cnt_a), 0);

        // Small instance: three frames
        apply_reset(3);
        exp_q = {1'b0, 1'b0};
        hs_rises.delete();
        hs_falls.delete();
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        de_cnt = 0;
        for (int k = 0; k < 3 * S_HT * S_VT + 20; k++) begin
            if (k > 0) @(negedge clk);
            x = k % S_HT;
            y = (k / S_HT) % S_VT;
            act = (x < S_HA) && (y < S_VA);
            ra = (y < S_VA) ? y * S_HA + ((x < S_HA) ? x : S_HA) : 0;
            if (ra == S_HA * S_VA) ra = 0;
            check("ra_s", 32'(read_addr_s), 32'(ra));
            exp_pix = exp_q.pop_front();
            check("pix_s", 32'(pix_s), 32'(exp_pix));
            exp_q.push_back(act ? pat_s(6'(ra)) : 1'b0);
            blank_s = !act;
            if (swap_s) sw.push_back(k);
            if (hsync_s && !prev_hs) hs_rises.push_back(k);
            if (!hsync_s && prev_hs) hs_falls.push_back(k);
            if (vsync_s && !prev_vs) vs_rises.push_back(k);
            if (!vsync_s && prev_vs) vs_falls.push_back(k);
            if (k < 194 && de_s) de_cnt++;
            prev_hs = hsync_s;
            prev_vs = vsync_s;
        end
        check("swap_n", 32'(sw.size()), 3);
        check("swap0", 32'(sw[0]), 96);
        check("swap1", 32'(sw[1]), 288);
        check("swap2", 32'(sw[2]), 480);
        check("vs_falls_n", 32'(vs_falls.size()), 3);
        check("vs_fall0", 32'(vs_falls[0]), 130);
        check("vs_rise0", 32'(vs_rises[0]), 162);
        check("vs_fall1", 32'(vs_falls[1]), 322);
        check("hs_fall0_s", 32'(hs_falls[0]), 12);
        check("hs_rise0_s", 32'(hs_rises[0]), 15);
        check("hs_fall1_s", 32'(hs_falls[1]), 28);
        check("de_cnt_f0", 32'(de_cnt), 48);

        // Mid-frame asynchronous reset at counter (5,3)
        apply_reset(2);
        for (int k = 0; k < 54; k++) begin
            if (k > 0) @(negedge clk);
            x = k % S_HT;
            y = (k / S_HT) % S_VT;
            blank_s = !((x < S_HA) && (y < S_VA));
        end
        check("mid_ra", 32'(read_addr_s), 29);
        check("mid_de", 32'(de_s), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_s("arst");
        check_idle_a("arst");
        repeat (3) begin
            @(negedge clk);
            check("swap_in_rst", 32'(swap_s), 0);
        end
        rst_n = 1'b1;
        sw.delete();
        for (int k = 0; k < 110; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) check("restart_ra0", 32'(read_addr_s), 0);
            if (k == 1) check("restart_ra1", 32'(read_addr_s), 1);
            if (swap_s) sw.push_back(k);
        end
        check("restart_swap_n", 32'(sw.size()), 1);
        check("restart_swap0", 32'(sw[0]), 96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
